// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between eight requesters and the
// round-robin arbiter. The master side (the requesters) drives req/done;
// the slave side (the arbiter) drives the grant outputs.
interface rr_arbiter8_if;
    logic [7:0] req;        // bit i = requester i wants the resource
    logic       done;       // release pulse from the current grant holder
    logic [7:0] gnt;        // one-hot grant, zero when idle
    logic [2:0] gnt_idx;    // index of current / last grantee
    logic       gnt_valid;  // high while a grant is active
    logic       timeout;    // one-cycle pulse on forced revocation

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a one-hot grant bus.
// A winner is picked in IDLE by scanning req from the round-robin pointer,
// held in GRANT until done, a dropped request or (optionally) a hold timeout,
// and every release returns to IDLE for at least one cycle.
// Optional feature: define RR_ARB_TIMEOUT_EN to compile in the hold counter
// that revokes a grant after HOLD_MAX visible cycles; otherwise timeout is 0.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16  // 1..255, used only with RR_ARB_TIMEOUT_EN
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter8_if.slave   bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;

    logic [2:0] winner;
    logic       win_found;
    logic       expire;

    // Reject out-of-range hold limits at elaboration time.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter8: HOLD_MAX must be in 1..255");
    end

    // Find the first requester at or after the pointer, wrapping modulo 8.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        winner    = ptr_q;
        win_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!win_found && bus.req[ptr_q + 3'(i)]) begin
                winner    = ptr_q + 3'(i);
                win_found = 1'b1;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    // The limit is reached on the edge after HOLD_MAX visible grant cycles.
    assign expire = (state_q == S_GRANT) && (hold_q == 8'(HOLD_MAX - 1));

    // Count cycles spent in GRANT; IDLE keeps it cleared for the next grant.
    always_comb begin
        hold_d = (state_q == S_GRANT) ? hold_q + 8'd1 : 8'd0;
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= 8'd0;
        else     hold_q <= hold_d;
    end
`else
    assign expire = 1'b0;
`endif

    // Next-state and next-output logic for the two-state arbiter.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    idx_d   = winner;
                    gnt_d   = 8'b1 << winner;
                    ptr_d   = winner + 3'd1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (bus.done || !bus.req[idx_q] || expire) begin
                    state_d   = S_IDLE;
                    gnt_d     = 8'h00;
                    // A forced revocation is reported only when nothing else
                    // would have released the grant on this edge.
                    timeout_d = expire && !bus.done && bus.req[idx_q];
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 8'h00;
            end
        endcase
    end

    // State, pointer and registered outputs; reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            gnt_q     <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == S_GRANT);
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed scenarios plus randomized traffic for rr_arbiter8,
// compared against a behavioural model of the round-robin rules.
// Build with RR_ARB_TIMEOUT_EN defined or not; the bench follows the macro.
module tb_rr_arbiter8;

    localparam int HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who holds the resource, where the scan starts next,
    // how many cycles the current grant has been visible.
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_hold;
    bit m_to;

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic d);
        bit exp_now;
        m_to = 0;
        if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (r[j]) begin
                    m_idx  = j;
                    m_ptr  = (j + 1) % 8;
                    m_busy = 1;
                    m_hold = 1;
                    break;
                end
            end
        end else begin
            exp_now = TO_EN && (m_hold == HOLD);
            if (d || !r[m_idx] || exp_now) begin
                m_busy = 0;
                m_to   = exp_now && !d && r[m_idx];
            end else begin
                m_hold++;
            end
        end
    endtask

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        g = m_busy ? 8'(1 << m_idx) : 8'h00;
        return {g, 3'(m_idx), m_busy, m_to};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
    endfunction

    // One clock edge: model sees the inputs present at the edge, then the
    // bench moves 1 time unit past the edge before anything is sampled.
    task automatic step();
        @(posedge clk);
        model_edge(bus.req, bus.done);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 8'hFF; bus.done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== 13'h0000) begin
            n_fail++;
            $display("FAIL reset_idle: got %h required %h", dut_vec(), 13'h0000);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.gnt !== 8'h01 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %h required %h", dut_vec(), exp_vec());
        end
        // Mid-grant reset must clear outputs before any further clock edge.
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h required %h", dut_vec(), 13'h0000);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_round_robin();
        bus.req = 8'hFF; bus.done = 1'b0;
        for (int g = 0; g < 9; g++) begin
            step();
            n_checks++;
            if (bus.gnt !== 8'(1 << (g % 8)) || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %h required gnt %h", g, dut_vec(), 8'(1 << (g % 8)));
            end
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            n_checks++;
            if (bus.gnt !== 8'h00 || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_release_%0d: got %h required %h", g, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [7:0] want [3];
        want[0] = 8'h40; want[1] = 8'h01; want[2] = 8'h40;
        bus.req = 8'h40;
        for (int g = 0; g < 3; g++) begin
            step();
            n_checks++;
            if (bus.gnt !== want[g] || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sparse_grant_%0d: got %h required gnt %h", g, dut_vec(), want[g]);
            end
            bus.done = 1'b1; bus.req = 8'h41;
            step();
            bus.done = 1'b0;
        end
        bus.req = 8'h00;
        step();
    endtask

    task automatic test_req_drop();
        bus.req = 8'h08;
        step();
        n_checks++;
        if (bus.gnt !== 8'h08 || bus.gnt_idx !== 3'd3 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL drop_grant: got %h required %h", dut_vec(), exp_vec());
        end
        bus.req = 8'h00;
        step();
        n_checks++;
        if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0 || bus.gnt_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL drop_release: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_timeout();
        bus.req = 8'h05; bus.done = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        for (int c = 0; c < HOLD; c++) begin
            step();
            n_checks++;
            if (bus.gnt !== 8'h01 || bus.timeout !== 1'b0 || dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL to_hold_%0d: got %h required gnt 01", c, dut_vec());
            end
        end
        step();
        n_checks++;
        if (bus.gnt !== 8'h00 || bus.timeout !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL to_revoke: got %h required gnt 00 timeout 1", dut_vec());
        end
        step();
        n_checks++;
        if (bus.gnt !== 8'h04 || bus.timeout !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL to_next_grant: got %h required gnt 04 timeout 0", dut_vec());
        end
        repeat (HOLD - 1) step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        n_checks++;
        if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL to_done_coincide: got %h required gnt 00 timeout 0", dut_vec());
        end
`else
        for (int c = 0; c < 110; c++) begin
            step();
            n_checks++;
            if (bus.gnt !== 8'h01 || bus.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL no_to_hold_%0d: got %h required gnt 01 timeout 0", c, dut_vec());
            end
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        n_checks++;
        if (bus.gnt !== 8'h00 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL no_to_release: got %h required %h", dut_vec(), exp_vec());
        end
`endif
        bus.req = 8'h00;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
            bus.done = ($urandom_range(0, 5) == 0);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
        bus.req = 8'h00; bus.done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_req_drop();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
